sifting_node: RTL and testbench

- One BB84-style sifting peer; ROLE parameter selects Alice (transmitter) or Bob (receiver).
- Two instances are cross-connected over an 8-bit GMII-style byte link.
- Bob announces per-slot detection/basis. Alice replies with per-slot keep/check flags.
- Each side packs sifted bits into 64-bit words for a key BRAM. Alice also reports visibility counts.

---
 rtl/sifting_pkg.sv | 41 ++++
 rtl/sift_key_packer.sv | 79 +++++++
 rtl/sifting_node.sv | 337 +++++++++++++++++++++++++++++++++
 tb/tb_sifting_node.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sifting_pkg.sv
// -----------------------------------------------------------------------------
// sifting_pkg
// Shared constants and types for the BB84 sifting peer (sifting_node) and its
// key packer (sift_key_packer).
//   - SFD          : frame start delimiter on the byte link
//   - ROLE_*       : values for the sifting_node ROLE parameter
//   - state_e      : sifting FSM states
//   - SB_*         : bit positions inside a slot byte
//   - KEY_W/ADDR_W : key BRAM word and address widths
// -----------------------------------------------------------------------------
package sifting_pkg;

    localparam logic [7:0] SFD = 8'hD5;

    localparam int ROLE_ALICE = 0;
    localparam int ROLE_BOB   = 1;

    localparam int KEY_W  = 64;
    localparam int ADDR_W = 15;

    // Bob -> Alice slot byte: {5'b0, bit & basis, basis, det}
    localparam int SB_DET   = 0;
    localparam int SB_BASIS = 1;
    localparam int SB_CBIT  = 2;

    // Alice -> Bob slot byte: {6'b0, check, keep}
    localparam int SB_KEEP  = 0;
    localparam int SB_CHECK = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_TX,
        ST_SEND,
        ST_RECV,
        ST_SIFT,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/sift_key_packer.sv
// -----------------------------------------------------------------------------
// sift_key_packer
// Packs sifted key bits LSB first into KEY_W-bit words and writes each full
// word to the key BRAM port. On the last slot of a round any partial word
// holding at least one bit is written zero-padded. The write address advances
// after every write, wraps at 2**ADDR_W and is cleared only by reset.
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   bit_valid        : bit_in is a kept key bit this cycle
//   bit_in           : key bit value
//   last_slot        : final slot of the round, flush the partial word
//   key_dina         : write data (zero when not writing)
//   key_addra        : write address
//   key_ena/key_wea  : one-cycle write strobe
// -----------------------------------------------------------------------------
module sift_key_packer
    import sifting_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_valid,
    input  logic              bit_in,
    input  logic              last_slot,
    output logic [KEY_W-1:0]  key_dina,
    output logic [ADDR_W-1:0] key_addra,
    output logic              key_ena,
    output logic              key_wea
);

    localparam int FILL_W = $clog2(KEY_W) + 1;

    logic [KEY_W-1:0]  word_q, word_d, word_n;
    logic [FILL_W-1:0] fill_q, fill_d, fill_n;
    logic              ena_q, ena_d;
    logic [KEY_W-1:0]  dina_q, dina_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr;

    always_comb begin
        // NOTE: every variable gets a default at the top so no path through
        // this block leaves one unassigned, which would infer a latch.
        word_n = word_q;
        if (bit_valid) begin
            word_n[fill_q[FILL_W-2:0]] = bit_in;
        end
        fill_n = fill_q + FILL_W'(bit_valid);
        wr     = (fill_n == FILL_W'(KEY_W)) || (last_slot && (fill_n != '0));
        word_d = wr ? '0 : word_n;
        fill_d = wr ? '0 : fill_n;
        ena_d  = wr;
        dina_d = wr ? word_n : '0;
        // Address moves on the edge that ends the write cycle.
        addr_d = addr_q + ADDR_W'(ena_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge value of its neighbours.
        if (!rst_n) begin
            word_q <= '0;
            fill_q <= '0;
            ena_q  <= 1'b0;
            dina_q <= '0;
            addr_q <= '0;
        end else begin
            word_q <= word_d;
            fill_q <= fill_d;
            ena_q  <= ena_d;
            dina_q <= dina_d;
            addr_q <= addr_d;
        end
    end

    assign key_dina  = dina_q;
    assign key_addra = addr_q;
    assign key_ena   = ena_q;
    assign key_wea   = ena_q;

endmodule

// File: rtl/sifting_node.sv
// -----------------------------------------------------------------------------
// sifting_node
// One BB84 sifting peer. ROLE selects Alice (0, transmitter) or Bob (1,
// receiver). Bob announces per-slot detection/basis, Alice answers with
// per-slot keep/check flags; both sides pack kept bits into the key BRAM and
// Alice accumulates visibility counts over the check slots.
// Optional build macro: SIFT_FRAME_CHK_EN appends an XOR checksum byte to
// every frame and checks it on receive.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   link_status           : link up; loss during SEND/RECV is fatal
//   start_switch          : rising edge in IDLE starts a round
//   start_tx / wait_tx    : transmit permission / waiting for it
//   rec_valid/rec_ready   : local record handshake (det, basis, bit)
//   rec_det, rec_basis, rec_bit : local record fields
//   txd, tx_en, tx_er     : byte link transmit (tx_er tied 0)
//   rxd, rx_dv, rx_er     : byte link receive
//   key_dina/addra/ena/wea: key BRAM write port
//   nvis, checkkey_1/0, compare_1/0 : Alice visibility counters (Bob: 0)
//   visibility_valid, sifting_finish : round completion pulses
//   sift_error            : sticky error, cleared by reset only
// -----------------------------------------------------------------------------
module sifting_node
    import sifting_pkg::*;
#(
    parameter int ROLE    = 0,
    parameter int N_SLOTS = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              link_status,
    input  logic              start_switch,
    input  logic              start_tx,
    output logic              wait_tx,
    input  logic              rec_valid,
    output logic              rec_ready,
    input  logic              rec_det,
    input  logic              rec_basis,
    input  logic              rec_bit,
    output logic [7:0]        txd,
    output logic              tx_en,
    output logic              tx_er,
    input  logic [7:0]        rxd,
    input  logic              rx_dv,
    input  logic              rx_er,
    output logic [KEY_W-1:0]  key_dina,
    output logic [ADDR_W-1:0] key_addra,
    output logic              key_ena,
    output logic              key_wea,
    output logic [CNT_W-1:0]  nvis,
    output logic [CNT_W-1:0]  checkkey_1,
    output logic [CNT_W-1:0]  checkkey_0,
    output logic [CNT_W-1:0]  compare_1,
    output logic [CNT_W-1:0]  compare_0,
    output logic              visibility_valid,
    output logic              sifting_finish,
    output logic              sift_error
);

    localparam int   SLOT_W   = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int   IDX_W    = $clog2(N_SLOTS + 2);
    localparam logic IS_ALICE = (ROLE == ROLE_ALICE);
`ifdef SIFT_FRAME_CHK_EN
    localparam int   FRAME_LEN = N_SLOTS + 2;
`else
    localparam int   FRAME_LEN = N_SLOTS + 1;
`endif

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             rx_act_q, rx_act_d;
    logic             start_prev_q;
    logic [CNT_W-1:0] nvis_q, nvis_d, ck1_q, ck1_d, ck0_q, ck0_d;
    logic [CNT_W-1:0] cmp1_q, cmp1_d, cmp0_q, cmp0_d;
`ifdef SIFT_FRAME_CHK_EN
    logic [7:0]       chk_q, chk_d;
`endif

    // Per-slot storage: local record and the peer's announcement byte.
    logic             loc_det   [N_SLOTS];
    logic             loc_basis [N_SLOTS];
    logic             loc_bit   [N_SLOTS];
    logic [2:0]       peer_q    [N_SLOTS];

    logic              start_edge, load_we, peer_we, recv_done;
    logic              sift_valid, sift_keep, sift_last;
    logic [SLOT_W-1:0] slot_idx;
    logic              my_det, my_basis, my_bit, keep_a, check_a;
    logic [2:0]        peer_cur;
    logic [7:0]        slot_byte, tx_byte;

    assign start_edge = start_switch & ~start_prev_q;

    // Slot under consideration: SEND is one byte behind cnt_q because of the
    // SFD, SIFT walks cnt_q directly.
    always_comb begin
        slot_idx = cnt_q[SLOT_W-1:0] - ((state_q == ST_SEND) ? SLOT_W'(1) : SLOT_W'(0));
        my_det   = loc_det[slot_idx];
        my_basis = loc_basis[slot_idx];
        my_bit   = loc_bit[slot_idx];
        peer_cur = peer_q[slot_idx];
        keep_a   = peer_cur[SB_DET] & ~peer_cur[SB_BASIS] & ~my_basis;
        check_a  = peer_cur[SB_DET] &  peer_cur[SB_BASIS] &  my_basis;
        slot_byte = '0;
        if (IS_ALICE) begin
            slot_byte[SB_KEEP]  = keep_a;
            slot_byte[SB_CHECK] = check_a;
        end else begin
            slot_byte[SB_DET]   = my_det;
            slot_byte[SB_BASIS] = my_basis;
            // Bob only reveals the bit value in the check basis.
            slot_byte[SB_CBIT]  = my_bit & my_basis;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rx_act_d   = rx_act_q;
        nvis_d     = nvis_q;
        ck1_d      = ck1_q;
        ck0_d      = ck0_q;
        cmp1_d     = cmp1_q;
        cmp0_d     = cmp0_q;
`ifdef SIFT_FRAME_CHK_EN
        chk_d      = chk_q;
`endif
        load_we    = 1'b0;
        peer_we    = 1'b0;
        recv_done  = 1'b0;
        sift_valid = 1'b0;
        sift_keep  = 1'b0;
        sift_last  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    nvis_d  = '0;
                    ck1_d   = '0;
                    ck0_d   = '0;
                    cmp1_d  = '0;
                    cmp0_d  = '0;
                end
            end
            ST_LOAD: begin
                if (rec_valid) begin
                    load_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(N_SLOTS - 1)) begin
                        cnt_d    = '0;
                        rx_act_d = 1'b0;
                        state_d  = IS_ALICE ? ST_RECV : ST_WAIT_TX;
                    end
                end
            end
            ST_WAIT_TX: begin
                if (start_tx && link_status) begin
                    state_d = ST_SEND;
                    cnt_d   = '0;
`ifdef SIFT_FRAME_CHK_EN
                    chk_d   = '0;
`endif
                end
            end
            ST_SEND: begin
                if (!link_status) begin
                    state_d = ST_ERR;
                end else begin
`ifdef SIFT_FRAME_CHK_EN
                    if ((cnt_q != '0) && (cnt_q <= IDX_W'(N_SLOTS))) begin
                        chk_d = chk_q ^ slot_byte;
                    end
`endif
                    if (cnt_q == IDX_W'(FRAME_LEN - 1)) begin
                        cnt_d    = '0;
                        rx_act_d = 1'b0;
                        state_d  = IS_ALICE ? ST_SIFT : ST_RECV;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (!link_status || rx_er) begin
                    state_d = ST_ERR;
                end else if (!rx_act_q) begin
                    // Hunt for the SFD; anything else on the link is noise.
                    if (rx_dv && (rxd == SFD)) begin
                        rx_act_d = 1'b1;
                        cnt_d    = '0;
`ifdef SIFT_FRAME_CHK_EN
                        chk_d    = '0;
`endif
                    end
                end else if (!rx_dv) begin
                    state_d = ST_ERR;
                end else if (cnt_q < IDX_W'(N_SLOTS)) begin
                    peer_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
`ifdef SIFT_FRAME_CHK_EN
                    chk_d   = chk_q ^ rxd;
`else
                    recv_done = (cnt_q == IDX_W'(N_SLOTS - 1));
`endif
                end
`ifdef SIFT_FRAME_CHK_EN
                else if (rxd != chk_q) begin
                    state_d = ST_ERR;
                end else begin
                    recv_done = 1'b1;
                end
`endif
                // Bytes after the frame are never looked at again this round.
                if (recv_done) begin
                    cnt_d    = '0;
                    rx_act_d = 1'b0;
                    state_d  = IS_ALICE ? ST_WAIT_TX : ST_SIFT;
                end
            end
            ST_SIFT: begin
                if (cnt_q < IDX_W'(N_SLOTS)) begin
                    sift_valid = 1'b1;
                    sift_last  = (cnt_q == IDX_W'(N_SLOTS - 1));
                    cnt_d      = cnt_q + 1'b1;
                    if (IS_ALICE && check_a) begin
                        nvis_d = nvis_q + 1'b1;
                        if (my_bit) ck1_d = ck1_q + 1'b1;
                        else        ck0_d = ck0_q + 1'b1;
                        if (my_bit && peer_cur[SB_CBIT])   cmp1_d = cmp1_q + 1'b1;
                        if (!my_bit && !peer_cur[SB_CBIT]) cmp0_d = cmp0_q + 1'b1;
                    end
                end else begin
                    // Extra cycle lets the packer's final write land before DONE.
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase

        if (sift_valid) begin
            sift_keep = IS_ALICE ? keep_a : peer_cur[SB_KEEP];
        end
    end

    always_comb begin
        tx_byte = '0;
        if ((state_q == ST_SEND) && link_status) begin
            if (cnt_q == '0) begin
                tx_byte = SFD;
            end else if (cnt_q <= IDX_W'(N_SLOTS)) begin
                tx_byte = slot_byte;
            end
`ifdef SIFT_FRAME_CHK_EN
            else begin
                tx_byte = chk_q;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rx_act_q     <= 1'b0;
            start_prev_q <= 1'b0;
            nvis_q       <= '0;
            ck1_q        <= '0;
            ck0_q        <= '0;
            cmp1_q       <= '0;
            cmp0_q       <= '0;
`ifdef SIFT_FRAME_CHK_EN
            chk_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rx_act_q     <= rx_act_d;
            start_prev_q <= start_switch;
            nvis_q       <= nvis_d;
            ck1_q        <= ck1_d;
            ck0_q        <= ck0_d;
            cmp1_q       <= cmp1_d;
            cmp0_q       <= cmp0_d;
`ifdef SIFT_FRAME_CHK_EN
            chk_q        <= chk_d;
`endif
        end
    end

    // NOTE: slot storage has no reset; every entry is rewritten during LOAD
    // and RECV before SEND or SIFT reads it, so it can map to plain RAM.
    always_ff @(posedge clk) begin
        if (load_we) begin
            loc_det[cnt_q[SLOT_W-1:0]]   <= rec_det;
            loc_basis[cnt_q[SLOT_W-1:0]] <= rec_basis;
            loc_bit[cnt_q[SLOT_W-1:0]]   <= rec_bit;
        end
        if (peer_we) begin
            peer_q[cnt_q[SLOT_W-1:0]] <= rxd[2:0];
        end
    end

    sift_key_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_valid (sift_valid & sift_keep),
        .bit_in    (my_bit),
        .last_slot (sift_last),
        .key_dina  (key_dina),
        .key_addra (key_addra),
        .key_ena   (key_ena),
        .key_wea   (key_wea)
    );

    assign wait_tx          = (state_q == ST_WAIT_TX);
    assign rec_ready        = (state_q == ST_LOAD);
    assign txd              = tx_byte;
    assign tx_en            = (state_q == ST_SEND) && link_status;
    assign tx_er            = 1'b0;
    assign nvis             = nvis_q;
    assign checkkey_1       = ck1_q;
    assign checkkey_0       = ck0_q;
    assign compare_1        = cmp1_q;
    assign compare_0        = cmp0_q;
    assign sifting_finish   = (state_q == ST_DONE);
    assign visibility_valid = IS_ALICE && (state_q == ST_DONE);
    // Link loss flags the error in the same cycle, before the FSM reaches ERR.
    assign sift_error       = (state_q == ST_ERR) ||
                              (!link_status && ((state_q == ST_SEND) || (state_q == ST_RECV)));

endmodule

// File: tb/tb_sifting_node.sv
module tb_sifting_node;
    import sifting_pkg::*;

    localparam int N = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic a_link = 1'b1, b_link = 1'b1, start_sw = 1'b0, inj_er = 1'b0;
    logic a_rec_valid = 1'b0, a_rec_basis = 1'b0, a_rec_bit = 1'b0;
    logic b_rec_valid = 1'b0, b_rec_det = 1'b0, b_rec_basis = 1'b0, b_rec_bit = 1'b0;

    logic        a_wait_tx, a_rec_ready, a_tx_en, a_tx_er, a_key_ena, a_key_wea;
    logic        b_wait_tx, b_rec_ready, b_tx_en, b_tx_er, b_key_ena, b_key_wea;
    logic [7:0]  a_txd, b_txd;
    logic [63:0] a_key_dina, b_key_dina;
    logic [14:0] a_key_addra, b_key_addra;
    logic [15:0] a_nvis, a_ck1, a_ck0, a_c1, a_c0, b_nvis, b_ck1, b_ck0, b_c1, b_c0;
    logic        a_vis, a_fin, a_err, b_vis, b_fin, b_err;

    sifting_node #(.ROLE(0), .N_SLOTS(N), .CNT_W(16)) u_alice (
        .clk(clk), .rst_n(rst_n), .link_status(a_link), .start_switch(start_sw),
        .start_tx(1'b1), .wait_tx(a_wait_tx), .rec_valid(a_rec_valid), .rec_ready(a_rec_ready),
        .rec_det(1'b1), .rec_basis(a_rec_basis), .rec_bit(a_rec_bit),
        .txd(a_txd), .tx_en(a_tx_en), .tx_er(a_tx_er),
        .rxd(b_txd), .rx_dv(b_tx_en), .rx_er(b_tx_er | inj_er),
        .key_dina(a_key_dina), .key_addra(a_key_addra), .key_ena(a_key_ena), .key_wea(a_key_wea),
        .nvis(a_nvis), .checkkey_1(a_ck1), .checkkey_0(a_ck0), .compare_1(a_c1), .compare_0(a_c0),
        .visibility_valid(a_vis), .sifting_finish(a_fin), .sift_error(a_err));

    sifting_node #(.ROLE(1), .N_SLOTS(N), .CNT_W(16)) u_bob (
        .clk(clk), .rst_n(rst_n), .link_status(b_link), .start_switch(start_sw),
        .start_tx(1'b1), .wait_tx(b_wait_tx), .rec_valid(b_rec_valid), .rec_ready(b_rec_ready),
        .rec_det(b_rec_det), .rec_basis(b_rec_basis), .rec_bit(b_rec_bit),
        .txd(b_txd), .tx_en(b_tx_en), .tx_er(b_tx_er),
        .rxd(a_txd), .rx_dv(a_tx_en), .rx_er(a_tx_er),
        .key_dina(b_key_dina), .key_addra(b_key_addra), .key_ena(b_key_ena), .key_wea(b_key_wea),
        .nvis(b_nvis), .checkkey_1(b_ck1), .checkkey_0(b_ck0), .compare_1(b_c1), .compare_0(b_c0),
        .visibility_valid(b_vis), .sifting_finish(b_fin), .sift_error(b_err));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Stimulus vectors and scoreboard state
    logic a_basis_v[N], a_bit_v[N], b_det_v[N], b_basis_v[N], b_bit_v[N];
    typedef struct { logic [14:0] addr; logic [63:0] data; } wr_t;
    wr_t q_a[$], q_b[$];
    logic [14:0] exp_addr_a = '0, exp_addr_b = '0;
    int exp_nvis, exp_ck1, exp_ck0, exp_c1, exp_c0;
    int fin_a = 0, fin_b = 0, wait_a = 0;

    // Scoreboard side: compare every key write against the queued expectation.
    always @(negedge clk) begin
        wr_t e;
        if (a_fin) fin_a++;
        if (b_fin) fin_b++;
        if (a_wait_tx) wait_a++;
        if (a_fin || a_vis) check("a_vis_with_fin", a_vis, a_fin);
        if (b_fin) check("b_vis_zero", b_vis, 0);
        if (a_key_ena) begin
            check("a_wea", a_key_wea, 1);
            if (q_a.size() == 0) check("a_unexpected_write", a_key_ena, 0);
            else begin
                e = q_a.pop_front();
                check("a_wr_addr", a_key_addra, e.addr);
                check("a_wr_data", a_key_dina, e.data);
            end
        end
        if (b_key_ena) begin
            check("b_wea", b_key_wea, 1);
            if (q_b.size() == 0) check("b_unexpected_write", b_key_ena, 0);
            else begin
                e = q_b.pop_front();
                check("b_wr_addr", b_key_addra, e.addr);
                check("b_wr_data", b_key_dina, e.data);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model of one round: pushes expected writes, sets expected counters.
    task automatic model_round();
        logic [63:0] wa, wb;
        int fill;
        logic keep, chk;
        wa = '0; wb = '0; fill = 0;
        exp_nvis = 0; exp_ck1 = 0; exp_ck0 = 0; exp_c1 = 0; exp_c0 = 0;
        for (int i = 0; i < N; i++) begin
            keep = b_det_v[i] & ~b_basis_v[i] & ~a_basis_v[i];
            chk  = b_det_v[i] &  b_basis_v[i] &  a_basis_v[i];
            if (keep) begin
                wa[fill] = a_bit_v[i];
                wb[fill] = b_bit_v[i];
                fill++;
                if (fill == 64) begin
                    q_a.push_back('{exp_addr_a, wa}); exp_addr_a++;
                    q_b.push_back('{exp_addr_b, wb}); exp_addr_b++;
                    wa = '0; wb = '0; fill = 0;
                end
            end
            if (chk) begin
                exp_nvis++;
                if (a_bit_v[i]) exp_ck1++; else exp_ck0++;
                if (a_bit_v[i] && b_bit_v[i]) exp_c1++;
                if (!a_bit_v[i] && !b_bit_v[i]) exp_c0++;
            end
        end
        if (fill > 0) begin
            q_a.push_back('{exp_addr_a, wa}); exp_addr_a++;
            q_b.push_back('{exp_addr_b, wb}); exp_addr_b++;
        end
    endtask

    task automatic start_and_load();
        start_sw = 1'b1;
        tick(1);
        start_sw = 1'b0;
        check("rec_ready_in_load", {a_rec_ready, b_rec_ready}, 2'b11);
        for (int i = 0; i < N; i++) begin
            a_rec_valid = 1'b1; a_rec_basis = a_basis_v[i]; a_rec_bit = a_bit_v[i];
            b_rec_valid = 1'b1; b_rec_det = b_det_v[i]; b_rec_basis = b_basis_v[i];
            b_rec_bit = b_bit_v[i];
            tick(1);
        end
        a_rec_valid = 1'b0;
        b_rec_valid = 1'b0;
    endtask

    task automatic run_round(input string name);
        int fa0, fb0, w0, cyc;
        fa0 = fin_a; fb0 = fin_b; w0 = wait_a;
        model_round();
        start_and_load();
        cyc = 0;
        while (!(fin_a > fa0 && fin_b > fb0) && cyc < 1000) begin
            tick(1);
            cyc++;
        end
        tick(3);
        check({name, "_a_finish"}, 64'(fin_a - fa0), 1);
        check({name, "_b_finish"}, 64'(fin_b - fb0), 1);
        check({name, "_a_wait_tx_seen"}, 64'(wait_a > w0), 1);
        check({name, "_a_nvis"}, a_nvis, 64'(exp_nvis));
        check({name, "_a_checkkey"}, {a_ck1, a_ck0}, {16'(exp_ck1), 16'(exp_ck0)});
        check({name, "_a_compare"}, {a_c1, a_c0}, {16'(exp_c1), 16'(exp_c0)});
        check({name, "_b_counters"}, {b_nvis, b_ck1, b_ck0, b_c1}, 0);
        check({name, "_pending_writes"}, 64'(q_a.size() + q_b.size()), 0);
        check({name, "_addr"}, {a_key_addra, b_key_addra}, {exp_addr_a, exp_addr_b});
        check({name, "_no_error"}, {a_err, b_err}, 0);
    endtask

    task automatic reset_and_check(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "_a_ctl"}, {a_tx_en, a_txd, a_key_ena, a_vis, a_fin, a_err, a_wait_tx, a_rec_ready}, 0);
        check({name, "_b_ctl"}, {b_tx_en, b_txd, b_key_ena, b_vis, b_fin, b_err, b_wait_tx, b_rec_ready}, 0);
        check({name, "_a_cnt"}, {a_nvis, a_ck1, a_ck0, a_c1}, 0);
        check({name, "_key"}, {a_key_addra, b_key_addra, a_c0, b_c0}, 0);
        check({name, "_dina"}, a_key_dina | b_key_dina, 0);
        tick(2);
        a_link = 1'b1; b_link = 1'b1;
        rst_n = 1'b1;
        exp_addr_a = '0; exp_addr_b = '0;
        q_a.delete(); q_b.delete();
        tick(2);
    endtask

    task automatic set_partial();
        for (int i = 0; i < N; i++) begin
            a_basis_v[i] = 1'b0; b_basis_v[i] = 1'b0;
            b_det_v[i] = (i < 10); a_bit_v[i] = 1'b1; b_bit_v[i] = 1'b1;
        end
    endtask

    initial begin
        int cyc, fa0, fb0, w0;
        tick(2);
        reset_and_check("reset");

        // Partial flush twice: 0x3FF at addr 0 then at addr 1.
        set_partial();
        run_round("partial1");
        run_round("partial2");

        // All key match: 0xAAAA... on each side.
        for (int i = 0; i < N; i++) begin
            a_basis_v[i] = 1'b0; b_basis_v[i] = 1'b0; b_det_v[i] = 1'b1;
            a_bit_v[i] = i[0]; b_bit_v[i] = i[0];
        end
        run_round("keymatch");

        // All check slots: Bob bits 0 in slots 0..3.
        for (int i = 0; i < N; i++) begin
            a_basis_v[i] = 1'b1; b_basis_v[i] = 1'b1; b_det_v[i] = 1'b1;
            a_bit_v[i] = 1'b1; b_bit_v[i] = (i >= 4);
        end
        run_round("allcheck");

        // No detection at all.
        for (int i = 0; i < N; i++) begin
            a_basis_v[i] = 1'b0; b_basis_v[i] = 1'b0; b_det_v[i] = 1'b0;
            a_bit_v[i] = 1'($urandom); b_bit_v[i] = 1'($urandom);
        end
        run_round("nodet");

        // Random mixes.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                a_basis_v[i] = 1'($urandom); b_basis_v[i] = 1'($urandom);
                b_det_v[i] = ($urandom_range(3, 0) != 0);
                a_bit_v[i] = 1'($urandom); b_bit_v[i] = 1'($urandom);
            end
            run_round("random");
        end

        // Link loss while Bob is sending.
        set_partial();
        fa0 = fin_a; fb0 = fin_b;
        start_and_load();
        cyc = 0;
        while (!b_tx_en && cyc < 50) begin tick(1); cyc++; end
        check("ll_b_sending", b_tx_en, 1);
        tick(5);
        b_link = 1'b0;
        #1;
        check("ll_b_err_now", b_err, 1);
        check("ll_b_tx_en_off", b_tx_en, 0);
        tick(200);
        b_link = 1'b1;
        tick(2);
        check("ll_b_err_sticky", b_err, 1);
        check("ll_a_err_dv_drop", a_err, 1);
        check("ll_no_finish", 64'((fin_a - fa0) + (fin_b - fb0)), 0);
        reset_and_check("ll_reset");

        // rx_er during Alice RECV.
        fa0 = fin_a; w0 = wait_a;
        start_and_load();
        cyc = 0;
        while (!b_tx_en && cyc < 50) begin tick(1); cyc++; end
        check("rxer_b_sending", b_tx_en, 1);
        tick(10);
        inj_er = 1'b1;
        tick(1);
        inj_er = 1'b0;
        check("rxer_a_err", a_err, 1);
        tick(300);
        check("rxer_no_wait_tx", 64'(wait_a - w0), 0);
        check("rxer_no_finish", 64'(fin_a - fa0), 0);
        reset_and_check("rxer_reset");

        // Address restarts at 0 after reset.
        set_partial();
        run_round("after_reset");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
